fpu_tag_tracker: RTL and testbench
==================================

Name: fpu_tag_tracker

Overview:
Parametrised successor to the per-block FPU tag store: allocates tags to FPU requests, holds request metadata until completion, and returns the metadata with the result. Adds per-warp fflags accumulation, so partial (sop..eop) packets from different warps may interleave, plus a sticky has-fflags bit and occupancy outputs. Sits between the FPU dispatch port and the FPU core (DPI/FPNEW/DSP) in each FPU block. An optional in-order release mode is available.

Parameters:
DATAW, 64, opaque metadata width (uuid, tmask, PC, rd, pid, ...).
SIZE, 8, tag/metadata entries; power of two, >= 2.
NUM_WARPS, 4, per-warp fflags accumulators.
TAG_WIDTH, derived = LOG2UP(SIZE), tag width.
NW_WIDTH, derived = UP(CLOG2(NUM_WARPS)), warp id width.
CNT_WIDTH, derived = CLOG2(SIZE+1), occupancy width.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  = ~full
req_data  in  DATAW  metadata to store
req_wid  in  NW_WIDTH  warp id
req_sop  in  1  first packet of instruction
req_eop  in  1  last packet of instruction
req_tag  out  TAG_WIDTH  tag allocated to the current request
cpl_valid  in  1  FPU core completion
cpl_ready  out  1  completion accepted
cpl_tag  in  TAG_WIDTH  completing tag
cpl_fflags  in  5  exception flags (fflags_t)
cpl_has_fflags  in  1  op produces flags
rsp_valid  out  1  response to result path
rsp_ready  in  1  result path accepts
rsp_data  out  DATAW  stored metadata
rsp_wid  out  NW_WIDTH  stored warp id
rsp_sop  out  1  stored sop
rsp_eop  out  1  stored eop
csr_we  out  1  fflags CSR write strobe
csr_wid  out  NW_WIDTH  CSR write warp
csr_fflags  out  5  accumulated flags
count  out  CNT_WIDTH  busy entries
full  out  1  count == SIZE
empty  out  1  count == 0

Behaviour:
- Reset (asynchronous on reset_n low, released synchronously to clk): all entries free; count 0; empty 1; full 0; req_ready 1; rsp_valid 0; csr_we 0; csr_wid 0; csr_fflags 0; all accumulators and sticky bits 0; in-order pointers and done bits 0. Reset asserted mid-operation discards all in-flight entries. No output is X after reset.
- Allocation: alloc_fire = req_valid & req_ready. req_tag = lowest-index free entry, combinational from the registered free mask. Metadata, wid, sop and eop are written at that index on the clock edge.
- Pass-through mode (default): rsp_valid = cpl_valid; cpl_ready = rsp_ready. rsp_* is a combinational read at cpl_tag. Entry is released on rel_fire = rsp_valid & rsp_ready. Latency is 0 cycles.
- Simultaneous alloc and release: both take effect; count is unchanged. req_tag is computed from the pre-release mask, so a tag is never reused in the cycle it frees. Full and alloc blocked while a release occurs: req_ready stays 0 that cycle and rises the next cycle.
- count: +1 on alloc only, -1 on release only, otherwise held.
- fflags, per warp w = rsp_wid, on rel_fire:
  - If eop: acc[w] <= 0 and sticky[w] <= 0.
  - Else: acc[w] <= acc[w] | (cpl_has_fflags ? cpl_fflags : 0) and sticky[w] <= sticky[w] | cpl_has_fflags.
- CSR write, registered with exactly 1 cycle of latency after rel_fire:
  - csr_we <= rel_fire & eop & (cpl_has_fflags | sticky[w]).
  - csr_fflags <= acc[w] | masked cpl_fflags.
  - csr_wid <= w.
  - Otherwise csr_we <= 0; csr_fflags and csr_wid hold.
- Protocol violations, caught by simulation assertions with no recovery: completion on a free tag; completion on a tag that is already done (in-order mode); req_valid dropped without fire is legal.

Optional Feature:
FPU_TRACKER_INORDER_EN
- Defined:
  - cpl_ready is tied to 1.
  - A completion records fflags/has_fflags per tag and sets done[tag] on the edge.
  - An order FIFO of SIZE entries holds tags in allocation order.
  - rsp_valid = done[head]; rsp_* are read at the head tag.
  - rel_fire pops the FIFO and clears done.
  - Completion-to-response latency is >= 1 cycle.
  - The fflags path uses the stored per-tag flags.
- Not defined: pass-through mode as above, with no order FIFO or done storage synthesised.

Decomposition:
- VX_fpu_pkg: reuse fflags_t; add FPU_TRACKER_FFLAGS_W = $bits(fflags_t).
- One sub-module, fpu_tag_free_list: free mask, lowest-free priority encoder, count/full/empty, alloc/release ports.
- The order FIFO reuses the existing FIFO primitive.

Test Plan:
- Reset, then 8 allocs with no completions -> tags 0..7; full=1, count=8, req_ready=0.
- Full; complete tag 3 while req_valid=1 -> tag 3 released; count 7. Next cycle req_ready=1, req_tag=3, count back to 8.
- Warp 1 packets sop, mid, eop with fflags 5'h01, 5'h04, 5'h00 (has=1) -> one cycle after eop release: csr_we=1, csr_wid=1, csr_fflags=5'h05.
- Interleave warp 0 (flags 5'h10) and warp 2 (flags 5'h02) partial packets -> independent CSR writes of 5'h10 and 5'h02; no cross-contamination.
- Single-packet op with has_fflags=0 -> csr_we stays 0. rsp_ready=0 with cpl_valid=1 -> cpl_ready=0 and the entry is retained.
- INORDER_EN: alloc tags 0,1,2; complete in order 2,0,1 -> responses emitted 0,1,2; each rsp_valid asserts >= 1 cycle after its completion.

Source files
------------

// File: rtl/fpu_tag_tracker_pkg.sv
// rtl/fpu_tag_tracker_pkg.sv - shared types, widths and helpers for the FPU tag tracker
package fpu_tag_tracker_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic ovf;
        logic uf;
        logic nx;
    } fflags_t;

    localparam int FPU_TRACKER_FFLAGS_W = $bits(fflags_t);

    // Never returns zero so single-entry or single-warp builds keep 1-bit fields.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpu_tag_tracker_if.sv
// rtl/fpu_tag_tracker_if.sv - dispatch, completion, response, CSR and occupancy bundle
interface fpu_tag_tracker_if
    import fpu_tag_tracker_pkg::*;
#(
    parameter int DATAW     = 64,
    parameter int SIZE      = 8,
    parameter int NUM_WARPS = 4
);
    localparam int TAG_WIDTH = log2up(SIZE);
    localparam int NW_WIDTH  = log2up(NUM_WARPS);
    localparam int CNT_WIDTH = $clog2(SIZE + 1);

    logic                 req_valid;
    logic                 req_ready;
    logic [DATAW-1:0]     req_data;
    logic [NW_WIDTH-1:0]  req_wid;
    logic                 req_sop;
    logic                 req_eop;
    logic [TAG_WIDTH-1:0] req_tag;

    logic                 cpl_valid;
    logic                 cpl_ready;
    logic [TAG_WIDTH-1:0] cpl_tag;
    fflags_t              cpl_fflags;
    logic                 cpl_has_fflags;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATAW-1:0]     rsp_data;
    logic [NW_WIDTH-1:0]  rsp_wid;
    logic                 rsp_sop;
    logic                 rsp_eop;

    logic                 csr_we;
    logic [NW_WIDTH-1:0]  csr_wid;
    fflags_t              csr_fflags;

    logic [CNT_WIDTH-1:0] count;
    logic                 full;
    logic                 empty;

    modport master (
        output req_valid, req_data, req_wid, req_sop, req_eop,
        input  req_ready, req_tag,
        output cpl_valid, cpl_tag, cpl_fflags, cpl_has_fflags,
        input  cpl_ready,
        input  rsp_valid, rsp_data, rsp_wid, rsp_sop, rsp_eop,
        output rsp_ready,
        input  csr_we, csr_wid, csr_fflags, count, full, empty
    );

    modport slave (
        input  req_valid, req_data, req_wid, req_sop, req_eop,
        output req_ready, req_tag,
        input  cpl_valid, cpl_tag, cpl_fflags, cpl_has_fflags,
        output cpl_ready,
        output rsp_valid, rsp_data, rsp_wid, rsp_sop, rsp_eop,
        input  rsp_ready,
        output csr_we, csr_wid, csr_fflags, count, full, empty
    );

endinterface

// File: rtl/fpu_tag_free_list.sv
// rtl/fpu_tag_free_list.sv - busy mask, lowest-free tag encoder and occupancy counter
module fpu_tag_free_list
    import fpu_tag_tracker_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int TAG_WIDTH = log2up(SIZE),
    parameter int CNT_WIDTH = $clog2(SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alloc,
    input  logic                 rel,
    input  logic [TAG_WIDTH-1:0] rel_idx,
    output logic [TAG_WIDTH-1:0] alloc_idx,
    output logic [SIZE-1:0]      busy,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);

    logic [SIZE-1:0]      busy_q, busy_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Scanning downward lets the last hit win, which is the lowest free index.
    always_comb begin
        alloc_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_idx = TAG_WIDTH'(i);
        end
    end

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        if (alloc) busy_d[alloc_idx] = 1'b1;
        if (rel)   busy_d[rel_idx]   = 1'b0;
        if (alloc && !rel)      count_d = count_q + CNT_WIDTH'(1);
        else if (rel && !alloc) count_d = count_q - CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy  = busy_q;
    assign count = count_q;
    assign full  = (count_q == CNT_WIDTH'(SIZE));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fpu_tag_tracker.sv
// rtl/fpu_tag_tracker.sv - FPU tag/metadata store with per-warp fflags accumulation
// FPU_TRACKER_INORDER_EN: release responses in allocation order via an order FIFO.
module fpu_tag_tracker
    import fpu_tag_tracker_pkg::*;
#(
    parameter int DATAW     = 64,
    parameter int SIZE      = 8,
    parameter int NUM_WARPS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    fpu_tag_tracker_if.slave  bus
);

    localparam int TAG_WIDTH = log2up(SIZE);
    localparam int NW_WIDTH  = log2up(NUM_WARPS);
    localparam int CNT_WIDTH = $clog2(SIZE + 1);
    localparam int FW        = FPU_TRACKER_FFLAGS_W;

    logic [TAG_WIDTH-1:0] alloc_idx;
    logic [SIZE-1:0]      busy;
    logic                 full;
    logic                 alloc_fire;
    logic                 rel_fire;
    logic                 rsp_valid;
    logic                 cpl_ready;
    logic [TAG_WIDTH-1:0] rel_tag;
    logic [FW-1:0]        eff_flags;
    logic                 eff_has;

    assign alloc_fire = bus.req_valid & ~full;
    assign rel_fire   = rsp_valid & bus.rsp_ready;

    fpu_tag_free_list #(
        .SIZE      (SIZE),
        .TAG_WIDTH (TAG_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_free_list (
        .clk       (clk),
        .reset_n   (reset_n),
        .alloc     (alloc_fire),
        .rel       (rel_fire),
        .rel_idx   (rel_tag),
        .alloc_idx (alloc_idx),
        .busy      (busy),
        .count     (bus.count),
        .full      (full),
        .empty     (bus.empty)
    );

    assign bus.full      = full;
    assign bus.req_ready = ~full;
    assign bus.req_tag   = alloc_idx;

    logic [DATAW-1:0]    data_q [SIZE];
    logic [DATAW-1:0]    data_d [SIZE];
    logic [NW_WIDTH-1:0] wid_q  [SIZE];
    logic [NW_WIDTH-1:0] wid_d  [SIZE];
    logic [SIZE-1:0]     sop_q, sop_d, eop_q, eop_d;

    always_comb begin
        data_d = data_q;
        wid_d  = wid_q;
        sop_d  = sop_q;
        eop_d  = eop_q;
        if (alloc_fire) begin
            data_d[alloc_idx] = bus.req_data;
            wid_d[alloc_idx]  = bus.req_wid;
            sop_d[alloc_idx]  = bus.req_sop;
            eop_d[alloc_idx]  = bus.req_eop;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SIZE; i++) begin
                data_q[i] <= '0;
                wid_q[i]  <= '0;
            end
            sop_q <= '0;
            eop_q <= '0;
        end else begin
            data_q <= data_d;
            wid_q  <= wid_d;
            sop_q  <= sop_d;
            eop_q  <= eop_d;
        end
    end

`ifdef FPU_TRACKER_INORDER_EN
    logic [TAG_WIDTH-1:0] ord_q [SIZE];
    logic [TAG_WIDTH-1:0] ord_d [SIZE];
    logic [TAG_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [SIZE-1:0]      done_q, done_d, thas_q, thas_d;
    logic [FW-1:0]        tflags_q [SIZE];
    logic [FW-1:0]        tflags_d [SIZE];

    assign cpl_ready = 1'b1;
    assign rel_tag   = ord_q[head_q];
    assign rsp_valid = done_q[rel_tag];
    assign eff_has   = thas_q[rel_tag];
    assign eff_flags = thas_q[rel_tag] ? tflags_q[rel_tag] : '0;

    // Occupancy never exceeds SIZE, so the order FIFO cannot overflow.
    always_comb begin
        ord_d    = ord_q;
        head_d   = head_q;
        tail_d   = tail_q;
        done_d   = done_q;
        thas_d   = thas_q;
        tflags_d = tflags_q;
        if (alloc_fire) begin
            ord_d[tail_q] = alloc_idx;
            tail_d        = tail_q + TAG_WIDTH'(1);
        end
        if (rel_fire) begin
            head_d          = head_q + TAG_WIDTH'(1);
            done_d[rel_tag] = 1'b0;
        end
        if (bus.cpl_valid) begin
            done_d[bus.cpl_tag]   = 1'b1;
            thas_d[bus.cpl_tag]   = bus.cpl_has_fflags;
            tflags_d[bus.cpl_tag] = bus.cpl_fflags;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SIZE; i++) begin
                ord_q[i]    <= '0;
                tflags_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
            thas_q <= '0;
        end else begin
            ord_q    <= ord_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            done_q   <= done_d;
            thas_q   <= thas_d;
            tflags_q <= tflags_d;
        end
    end

    a_cpl_not_done: assert property (@(posedge clk) disable iff (!reset_n)
        bus.cpl_valid |-> !done_q[bus.cpl_tag]);
`else
    assign cpl_ready = bus.rsp_ready;
    assign rel_tag   = bus.cpl_tag;
    assign rsp_valid = bus.cpl_valid;
    assign eff_has   = bus.cpl_has_fflags;
    assign eff_flags = bus.cpl_has_fflags ? bus.cpl_fflags : '0;
`endif

    a_cpl_busy: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.cpl_valid && cpl_ready) |-> busy[bus.cpl_tag]);

    assign bus.cpl_ready = cpl_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = data_q[rel_tag];
    assign bus.rsp_wid   = wid_q[rel_tag];
    assign bus.rsp_sop   = sop_q[rel_tag];
    assign bus.rsp_eop   = eop_q[rel_tag];

    logic [FW-1:0]       acc_q [NUM_WARPS];
    logic [FW-1:0]       acc_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] sticky_q, sticky_d;
    logic                csr_we_q, csr_we_d;
    logic [NW_WIDTH-1:0] csr_wid_q, csr_wid_d;
    logic [FW-1:0]       csr_fflags_q, csr_fflags_d;
    logic [NW_WIDTH-1:0] rel_wid;
    logic                rel_eop;

    assign rel_wid = wid_q[rel_tag];
    assign rel_eop = eop_q[rel_tag];

    // The eop packet folds its own flags into the CSR write and resets the warp.
    always_comb begin
        acc_d        = acc_q;
        sticky_d     = sticky_q;
        csr_we_d     = 1'b0;
        csr_wid_d    = csr_wid_q;
        csr_fflags_d = csr_fflags_q;
        if (rel_fire) begin
            if (rel_eop) begin
                acc_d[rel_wid]    = '0;
                sticky_d[rel_wid] = 1'b0;
                if (eff_has || sticky_q[rel_wid]) begin
                    csr_we_d     = 1'b1;
                    csr_wid_d    = rel_wid;
                    csr_fflags_d = acc_q[rel_wid] | eff_flags;
                end
            end else begin
                acc_d[rel_wid]    = acc_q[rel_wid] | eff_flags;
                sticky_d[rel_wid] = sticky_q[rel_wid] | eff_has;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WARPS; i++) acc_q[i] <= '0;
            sticky_q     <= '0;
            csr_we_q     <= 1'b0;
            csr_wid_q    <= '0;
            csr_fflags_q <= '0;
        end else begin
            acc_q        <= acc_d;
            sticky_q     <= sticky_d;
            csr_we_q     <= csr_we_d;
            csr_wid_q    <= csr_wid_d;
            csr_fflags_q <= csr_fflags_d;
        end
    end

    assign bus.csr_we     = csr_we_q;
    assign bus.csr_wid    = csr_wid_q;
    assign bus.csr_fflags = csr_fflags_q;

endmodule

// File: tb/tb_fpu_tag_tracker.sv
// tb/tb_fpu_tag_tracker.sv - directed self-checking bench for fpu_tag_tracker
module tb_fpu_tag_tracker;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fpu_tag_tracker_if #(.DATAW(64), .SIZE(8), .NUM_WARPS(4)) bus ();

    fpu_tag_tracker #(.DATAW(64), .SIZE(8), .NUM_WARPS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid      = 1'b0;
        bus.req_data       = '0;
        bus.req_wid        = '0;
        bus.req_sop        = 1'b0;
        bus.req_eop        = 1'b0;
        bus.cpl_valid      = 1'b0;
        bus.cpl_tag        = '0;
        bus.cpl_fflags     = '0;
        bus.cpl_has_fflags = 1'b0;
        bus.rsp_ready      = 1'b0;
    endtask

    task automatic do_alloc(input logic [63:0] d, input int w, input logic s, input logic e,
                            input int exp_tag);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_wid   = 2'(w);
        bus.req_sop   = s;
        bus.req_eop   = e;
        #1;
        chk("alloc_req_ready", 64'(bus.req_ready), 64'd1);
        chk("alloc_req_tag", 64'(bus.req_tag), 64'(exp_tag));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_cpl(input int tag, input logic [4:0] f, input logic has,
                          input logic [63:0] exp_data, input int exp_wid);
        @(negedge clk);
        bus.cpl_valid      = 1'b1;
        bus.cpl_tag        = 3'(tag);
        bus.cpl_fflags     = f;
        bus.cpl_has_fflags = has;
        bus.rsp_ready      = 1'b1;
        #1;
        chk("cpl_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("cpl_rsp_data", bus.rsp_data, exp_data);
        chk("cpl_rsp_wid", 64'(bus.rsp_wid), 64'(exp_wid));
        @(posedge clk);
        #1;
        bus.cpl_valid = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic chk_csr(input logic we, input int wid, input logic [4:0] f);
        @(negedge clk);
        #1;
        chk("csr_we", 64'(bus.csr_we), 64'(we));
        if (we) begin
            chk("csr_wid", 64'(bus.csr_wid), 64'(wid));
            chk("csr_fflags", 64'(bus.csr_fflags), 64'(f));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_async_count", 64'(bus.count), 64'd0);
        chk("rst_async_empty", 64'(bus.empty), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_req_tag", 64'(bus.req_tag), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_csr_we", 64'(bus.csr_we), 64'd0);
        chk("rst_csr_wid", 64'(bus.csr_wid), 64'd0);
        chk("rst_csr_fflags", 64'(bus.csr_fflags), 64'd0);

        for (int i = 0; i < 8; i++) do_alloc(64'hA5A5_0000_0000_0000 | 64'(i), i % 4, 1'b1, 1'b1, i);
        @(negedge clk);
        #1;
        chk("fill_full", 64'(bus.full), 64'd1);
        chk("fill_count", 64'(bus.count), 64'd8);
        chk("fill_req_ready", 64'(bus.req_ready), 64'd0);

`ifdef FPU_TRACKER_INORDER_EN
        pulse_reset();
        for (int i = 0; i < 3; i++) do_alloc(64'h100 + 64'(i), 0, 1'b1, 1'b1, i);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.cpl_valid = 1'b1;
        bus.cpl_tag   = 3'd2;
        #1;
        chk("io_cpl_ready", 64'(bus.cpl_ready), 64'd1);
        chk("io_wait_head0_a", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.cpl_tag = 3'd0;
        @(negedge clk);
        #1;
        chk("io_latency_tag0", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.cpl_tag = 3'd1;
        @(negedge clk);
        #1;
        chk("io_rsp0_valid", 64'(bus.rsp_valid), 64'd1);
        chk("io_rsp0_data", bus.rsp_data, 64'h100);
        @(posedge clk);
        #1;
        bus.cpl_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("io_rsp1_valid", 64'(bus.rsp_valid), 64'd1);
        chk("io_rsp1_data", bus.rsp_data, 64'h101);
        @(negedge clk);
        #1;
        chk("io_rsp2_valid", 64'(bus.rsp_valid), 64'd1);
        chk("io_rsp2_data", bus.rsp_data, 64'h102);
        @(negedge clk);
        #1;
        chk("io_drained_valid", 64'(bus.rsp_valid), 64'd0);
        chk("io_drained_count", 64'(bus.count), 64'd0);
        bus.rsp_ready = 1'b0;
`else
        // Release tag 3 while full and a request is waiting.
        @(negedge clk);
        bus.req_valid      = 1'b1;
        bus.req_data       = 64'hBEEF;
        bus.req_wid        = 2'd1;
        bus.req_sop        = 1'b1;
        bus.req_eop        = 1'b1;
        bus.cpl_valid      = 1'b1;
        bus.cpl_tag        = 3'd3;
        bus.rsp_ready      = 1'b1;
        #1;
        chk("full_rel_req_ready", 64'(bus.req_ready), 64'd0);
        chk("full_rel_cpl_ready", 64'(bus.cpl_ready), 64'd1);
        chk("full_rel_data", bus.rsp_data, 64'hA5A5_0000_0000_0003);
        chk("full_rel_wid", 64'(bus.rsp_wid), 64'd3);
        chk("full_rel_eop", 64'(bus.rsp_eop), 64'd1);
        @(posedge clk);
        #1;
        bus.cpl_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("after_rel_count", 64'(bus.count), 64'd7);
        chk("after_rel_req_ready", 64'(bus.req_ready), 64'd1);
        chk("after_rel_req_tag", 64'(bus.req_tag), 64'd3);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.cpl_valid = 1'b1;
        bus.cpl_tag   = 3'd3;
        @(negedge clk);
        #1;
        chk("refill_count", 64'(bus.count), 64'd8);
        chk("refill_full", 64'(bus.full), 64'd1);
        chk("refill_data", bus.rsp_data, 64'hBEEF);
        chk("refill_hold_cpl_ready", 64'(bus.cpl_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.cpl_valid = 1'b0;
        pulse_reset();

        // Warp 1: sop, mid, eop accumulate into one CSR write.
        do_alloc(64'h11, 1, 1'b1, 1'b0, 0);
        do_alloc(64'h12, 1, 1'b0, 1'b0, 1);
        do_alloc(64'h13, 1, 1'b0, 1'b1, 2);
        do_cpl(0, 5'h01, 1'b1, 64'h11, 1);
        chk_csr(1'b0, 0, 5'h00);
        do_cpl(1, 5'h04, 1'b1, 64'h12, 1);
        chk_csr(1'b0, 0, 5'h00);
        do_cpl(2, 5'h00, 1'b1, 64'h13, 1);
        chk_csr(1'b1, 1, 5'h05);
        chk("w1_drained_empty", 64'(bus.empty), 64'd1);

        // Warps 0 and 2 interleaved; eop packets carry no flags of their own.
        do_alloc(64'h20, 0, 1'b1, 1'b0, 0);
        do_alloc(64'h21, 2, 1'b1, 1'b0, 1);
        do_alloc(64'h22, 0, 1'b0, 1'b1, 2);
        do_alloc(64'h23, 2, 1'b0, 1'b1, 3);
        do_cpl(0, 5'h10, 1'b1, 64'h20, 0);
        chk_csr(1'b0, 0, 5'h00);
        do_cpl(1, 5'h02, 1'b1, 64'h21, 2);
        chk_csr(1'b0, 0, 5'h00);
        do_cpl(2, 5'h1F, 1'b0, 64'h22, 0);
        chk_csr(1'b1, 0, 5'h10);
        do_cpl(3, 5'h00, 1'b0, 64'h23, 2);
        chk_csr(1'b1, 2, 5'h02);

        // Back-pressure, then release with a same-cycle alloc.
        do_alloc(64'h30, 3, 1'b1, 1'b1, 0);
        @(negedge clk);
        bus.cpl_valid = 1'b1;
        bus.cpl_tag   = 3'd0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("stall_cpl_ready", 64'(bus.cpl_ready), 64'd0);
        chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        @(negedge clk);
        #1;
        chk("stall_count", 64'(bus.count), 64'd1);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_data  = 64'h31;
        bus.req_wid   = 2'd3;
        bus.req_sop   = 1'b1;
        bus.req_eop   = 1'b1;
        #1;
        chk("swap_req_tag", 64'(bus.req_tag), 64'd1);
        chk("swap_cpl_ready", 64'(bus.cpl_ready), 64'd1);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        #1;
        chk("swap_count", 64'(bus.count), 64'd1);
        chk("noflag_csr_we", 64'(bus.csr_we), 64'd0);
        do_cpl(1, 5'h00, 1'b0, 64'h31, 3);
        chk_csr(1'b0, 0, 5'h00);
        chk("final_empty", 64'(bus.empty), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
